// File: rtl/judge_pkg.sv
// Shared types and constants for the rhythm-game note judge: judgement
// codes, lane keycodes, score increments, FSM state encoding and small
// helpers used by the judge datapath.
package judge_pkg;

   // Judgement reported with each judge_valid pulse.
   typedef enum logic [1:0] {
      JUDGE_NONE    = 2'd0,
      JUDGE_PERFECT = 2'd1,
      JUDGE_GOOD    = 2'd2,
      JUDGE_MISS    = 2'd3
   } judge_t;

   // PS/2 make codes of the four arrow keys, one per lane.
   localparam logic [7:0] KC_LEFT  = 8'h6B;
   localparam logic [7:0] KC_DOWN  = 8'h72;
   localparam logic [7:0] KC_UP    = 8'h75;
   localparam logic [7:0] KC_RIGHT = 8'h74;

   // Points added to the score per graded hit.
   localparam logic [15:0] SCORE_PERFECT = 16'd3;
   localparam logic [15:0] SCORE_GOOD    = 16'd1;

   // Judge FSM: one key judgement or a four-step lane scan at a time.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_JUDGE = 3'd1,
      ST_SCAN0 = 3'd2,
      ST_SCAN1 = 3'd3,
      ST_SCAN2 = 3'd4,
      ST_SCAN3 = 3'd5
   } state_t;

   // Result of decoding a keycode into a lane.
   typedef struct packed {
      logic       hit;
      logic [1:0] lane;
   } key_map_t;

   // Map a PS/2 make code onto a lane; non-arrow keys report hit = 0.
   function automatic key_map_t map_key(input logic [7:0] kc);
      key_map_t m;
      m.hit  = 1'b1;
      m.lane = 2'd0;
      case (kc)
         KC_LEFT:  m.lane = 2'd0;
         KC_DOWN:  m.lane = 2'd1;
         KC_UP:    m.lane = 2'd2;
         KC_RIGHT: m.lane = 2'd3;
         default:  m.hit  = 1'b0;
      endcase
      return m;
   endfunction

   // 16-bit add that pins at all-ones instead of wrapping.
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane FIFO of pending note arrival times (frame numbers). A push while
// full is accepted only if a pop happens in the same cycle, so the lane can
// turn over a note even when it is saturated.
module lane_fifo #(
   parameter int DEPTH = 4
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic [15:0] din,
   output logic        full,
   output logic        empty,
   output logic [15:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [15:0] r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_do_push;
   logic        w_do_pop;

   // Extra pointer bit tells full from empty when the indices match.
   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                      (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);
   assign head      = r_mem[r_rd_ptr[AW-1:0]];

   // Advance read/write pointers on accepted pushes and pops.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state is written with <= so every register samples
      // the pre-edge values, independent of statement order.
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Write note times into storage; when full, this overwrites the slot
   // being popped in the same cycle.
   always_ff @(posedge Clk) begin
      // NOTE: the storage array is deliberately not reset; the pointers define
      // which entries are valid, and a reset-free array maps onto plain RAM.
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/note_judge.sv
// Rhythm-game judge: counts video frames, queues spawned notes per lane,
// grades arrow-key presses against the head note of their lane and sweeps
// all lanes once per frame to report notes that went by unhit. Produces a
// judgement pulse plus running score and combo.
module note_judge
   import judge_pkg::*;
#(
   parameter int TRAVEL_FRAMES = 120,
   parameter int PERFECT_WIN   = 3,
   parameter int GOOD_WIN      = 8,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        vsync,
   input  logic [7:0]  keycode,
   input  logic        press,
   input  logic [3:0]  note_spawn,
   output logic        judge_valid,
   output logic [1:0]  judge_code,
   output logic [1:0]  judge_lane,
   output logic [15:0] score,
   output logic [7:0]  combo,
   output logic        overflow
);

   localparam logic [15:0]        TRAVEL    = 16'(TRAVEL_FRAMES);
   localparam logic signed [15:0] POS_P_WIN = 16'(PERFECT_WIN);
   localparam logic signed [15:0] NEG_P_WIN = 16'(-PERFECT_WIN);
   localparam logic signed [15:0] POS_G_WIN = 16'(GOOD_WIN);
   localparam logic signed [15:0] NEG_G_WIN = 16'(-GOOD_WIN);

   // Edge detection and frame time
   logic        r_vsync_d;
   logic        r_press_d;
   logic [15:0] r_frame_cnt;
   logic        w_tick;
   logic        w_press_edge;
   key_map_t    w_key;

   // Pending work for the FSM
   logic        r_key_pending;
   logic [1:0]  r_key_lane;
   logic        r_scan_pending;
   state_t      r_state;
   state_t      w_next_state;
   logic        w_scanning;

   // Lane FIFOs
   logic [3:0]  w_full;
   logic [3:0]  w_empty;
   logic [3:0]  w_pop;
   logic [3:0]  w_drop;
   logic [15:0] w_head [4];
   logic [15:0] w_spawn_time;

   // Judgement datapath
   logic [1:0]        w_sel_lane;
   logic [15:0]       w_sel_head;
   logic              w_sel_empty;
   logic signed [15:0] w_delta;
   logic              w_emit;
   judge_t            w_code;

   // Registered outputs
   logic        r_judge_valid;
   judge_t      r_judge_code;
   logic [1:0]  r_judge_lane;
   logic [15:0] r_score;
   logic [7:0]  r_combo;
   logic        r_overflow;

   assign w_tick       = r_vsync_d & ~vsync;
   assign w_press_edge = press & ~r_press_d;
   assign w_key        = map_key(keycode);
   assign w_scanning   = (r_state == ST_SCAN0) || (r_state == ST_SCAN1) ||
                         (r_state == ST_SCAN2) || (r_state == ST_SCAN3);

   // Delay vsync and press by one cycle for edge detection.
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_vsync_d <= 1'b0;
         r_press_d <= 1'b0;
      end else begin
         r_vsync_d <= vsync;
         r_press_d <= press;
      end
   end

   // Count frames on each vsync falling edge; wraps naturally at 16 bits.
   always_ff @(posedge Clk) begin
      if (reset)       r_frame_cnt <= '0;
      else if (w_tick) r_frame_cnt <= r_frame_cnt + 16'd1;
   end

   // Capture one mapped key press at a time; edges seen while a key is
   // still waiting for judgement are dropped.
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_key_pending <= 1'b0;
         r_key_lane    <= 2'd0;
      end else if (r_state == ST_JUDGE) begin
         r_key_pending <= 1'b0;
      end else if (w_press_edge && w_key.hit && !r_key_pending) begin
         r_key_pending <= 1'b1;
         r_key_lane    <= w_key.lane;
      end
   end

   // Request a lane sweep per frame; ticks during an outstanding or running
   // sweep are absorbed, since that sweep already covers them.
   always_ff @(posedge Clk) begin
      if (reset)                                         r_scan_pending <= 1'b0;
      else if (w_next_state == ST_SCAN0)                 r_scan_pending <= 1'b0;
      else if (w_tick && !r_scan_pending && !w_scanning) r_scan_pending <= 1'b1;
   end

   // A spawned note is due TRAVEL_FRAMES after the current frame.
   assign w_spawn_time = r_frame_cnt + TRAVEL;
   assign w_drop       = note_spawn & w_full & ~w_pop;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      lane_fifo #(
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .Clk   (Clk),
         .reset (reset),
         .push  (note_spawn[g]),
         .pop   (w_pop[g]),
         .din   (w_spawn_time),
         .full  (w_full[g]),
         .empty (w_empty[g]),
         .head  (w_head[g])
      );
   end

   // Choose the lane under inspection: the pressed lane or the scan lane.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      w_sel_lane = r_key_lane;
      case (r_state)
         ST_SCAN0: w_sel_lane = 2'd0;
         ST_SCAN1: w_sel_lane = 2'd1;
         ST_SCAN2: w_sel_lane = 2'd2;
         ST_SCAN3: w_sel_lane = 2'd3;
         default:  w_sel_lane = r_key_lane;
      endcase
   end

   // Signed distance of now from the head note; positive means late. The
   // modular difference stays correct across a frame-counter wrap.
   assign w_sel_head  = w_head[w_sel_lane];
   assign w_sel_empty = w_empty[w_sel_lane];
   assign w_delta     = $signed(r_frame_cnt - w_sel_head);

   // FSM sequencing: a pending key always goes before a pending sweep.
   always_comb begin
      w_next_state = ST_IDLE;
      case (r_state)
         ST_IDLE: begin
            if (r_key_pending)       w_next_state = ST_JUDGE;
            else if (r_scan_pending) w_next_state = ST_SCAN0;
            else                     w_next_state = ST_IDLE;
         end
         ST_JUDGE: w_next_state = ST_IDLE;
         ST_SCAN0: w_next_state = ST_SCAN1;
         ST_SCAN1: w_next_state = ST_SCAN2;
         ST_SCAN2: w_next_state = ST_SCAN3;
         ST_SCAN3: w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Grade the selected head note; a too-early press leaves the note alone.
   always_comb begin
      w_emit = 1'b0;
      w_code = JUDGE_NONE;
      if (r_state == ST_JUDGE && !w_sel_empty) begin
         if (w_delta >= NEG_G_WIN) begin
            w_emit = 1'b1;
            if (w_delta >= NEG_P_WIN && w_delta <= POS_P_WIN) w_code = JUDGE_PERFECT;
            else if (w_delta <= POS_G_WIN)                    w_code = JUDGE_GOOD;
            else                                              w_code = JUDGE_MISS;
         end
      end else if (w_scanning && !w_sel_empty && w_delta > POS_G_WIN) begin
         w_emit = 1'b1;
         w_code = JUDGE_MISS;
      end
      w_pop = w_emit ? (4'b0001 << w_sel_lane) : 4'b0000;
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // Register the judgement pulse and accumulate score/combo.
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_judge_valid <= 1'b0;
         r_judge_code  <= JUDGE_NONE;
         r_judge_lane  <= 2'd0;
         r_score       <= '0;
         r_combo       <= '0;
      end else begin
         r_judge_valid <= w_emit;
         if (w_emit) begin
            r_judge_code <= w_code;
            r_judge_lane <= w_sel_lane;
            case (w_code)
               JUDGE_PERFECT: begin
                  r_score <= sat_add16(r_score, SCORE_PERFECT);
                  r_combo <= (r_combo == 8'hFF) ? 8'hFF : r_combo + 8'd1;
               end
               JUDGE_GOOD: begin
                  r_score <= sat_add16(r_score, SCORE_GOOD);
                  r_combo <= (r_combo == 8'hFF) ? 8'hFF : r_combo + 8'd1;
               end
               JUDGE_MISS: r_combo <= 8'd0;
               default:    r_combo <= r_combo;
            endcase
         end
      end
   end

   // Sticky flag for a spawn lost to a full lane.
   always_ff @(posedge Clk) begin
      if (reset)         r_overflow <= 1'b0;
      else if (|w_drop)  r_overflow <= 1'b1;
   end

   assign judge_valid = r_judge_valid;
   assign judge_code  = r_judge_code;
   assign judge_lane  = r_judge_lane;
   assign score       = r_score;
   assign combo       = r_combo;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_note_judge.sv
// Bench for note_judge: a lane/score model predicts each judgement when the
// stimulus is driven and queues it; a monitor pops and compares every
// judge_valid pulse against that queue.
module tb_note_judge;

   localparam int TRAVEL = 120;
   localparam int PWIN   = 3;
   localparam int GWIN   = 8;
   localparam int DEPTH  = 4;

   logic        Clk = 1'b0;
   logic        reset;
   logic        vsync;
   logic [7:0]  keycode;
   logic        press;
   logic [3:0]  note_spawn;
   logic        judge_valid;
   logic [1:0]  judge_code;
   logic [1:0]  judge_lane;
   logic [15:0] score;
   logic [7:0]  combo;
   logic        overflow;

   note_judge #(
      .TRAVEL_FRAMES (TRAVEL),
      .PERFECT_WIN   (PWIN),
      .GOOD_WIN      (GWIN),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .Clk         (Clk),
      .reset       (reset),
      .vsync       (vsync),
      .keycode     (keycode),
      .press       (press),
      .note_spawn  (note_spawn),
      .judge_valid (judge_valid),
      .judge_code  (judge_code),
      .judge_lane  (judge_lane),
      .score       (score),
      .combo       (combo),
      .overflow    (overflow)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [1:0]  code;
      logic [1:0]  lane;
      logic [15:0] score;
      logic [7:0]  combo;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] tb_frame;
   logic [15:0] exp_score;
   logic [7:0]  exp_combo;
   logic [15:0] m_q [4][DEPTH];
   int          m_cnt [4];

   // ---------------- model ----------------
   function automatic int kc_lane(input logic [7:0] kc);
      case (kc)
         8'h6B:   return 0;
         8'h72:   return 1;
         8'h75:   return 2;
         8'h74:   return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [1:0] grade(input logic [15:0] frame, input logic [15:0] head);
      logic signed [15:0] d;
      int di;
      d  = $signed(frame - head);
      di = d;
      if (di < -GWIN)                 return 2'd0;
      if (di >= -PWIN && di <= PWIN)  return 2'd1;
      if (di <= GWIN)                 return 2'd2;
      return 2'd3;
   endfunction

   task automatic m_pop(input int l);
      for (int k = 0; k < DEPTH - 1; k++) m_q[l][k] = m_q[l][k+1];
      m_cnt[l]--;
   endtask

   task automatic expect_judge(input logic [1:0] code, input int l);
      exp_t e;
      case (code)
         2'd1: begin
            exp_score = (exp_score > 16'hFFFC) ? 16'hFFFF : exp_score + 16'd3;
            exp_combo = (exp_combo == 8'hFF) ? 8'hFF : exp_combo + 8'd1;
         end
         2'd2: begin
            exp_score = (exp_score == 16'hFFFF) ? 16'hFFFF : exp_score + 16'd1;
            exp_combo = (exp_combo == 8'hFF) ? 8'hFF : exp_combo + 8'd1;
         end
         default: exp_combo = 8'd0;
      endcase
      e.code  = code;
      e.lane  = 2'(l);
      e.score = exp_score;
      e.combo = exp_combo;
      sb.push_back(e);
   endtask

   task automatic model_key(input logic [7:0] kc);
      int l;
      logic [1:0] g;
      l = kc_lane(kc);
      if (l >= 0 && m_cnt[l] > 0) begin
         g = grade(tb_frame, m_q[l][0]);
         if (g != 2'd0) begin
            m_pop(l);
            expect_judge(g, l);
         end
      end
   endtask

   task automatic model_scan();
      for (int l = 0; l < 4; l++) begin
         if (m_cnt[l] > 0 && grade(tb_frame, m_q[l][0]) == 2'd3) begin
            m_pop(l);
            expect_judge(2'd3, l);
         end
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge Clk) begin
      if (judge_valid === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_judge: got code=%0d lane=%0d score=%0d combo=%0d, required no judgement",
                     judge_code, judge_lane, score, combo);
         end else begin
            mon_e = sb.pop_front();
            if ({judge_code, judge_lane, score, combo} !== mon_e)
               $display("FAIL judge: got code=%0d lane=%0d score=%0d combo=%0d, required code=%0d lane=%0d score=%0d combo=%0d",
                        judge_code, judge_lane, score, combo, mon_e.code, mon_e.lane, mon_e.score, mon_e.combo);
            else
               n_pass++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(negedge Clk);
      reset = 1'b1; vsync = 1'b0; press = 1'b0; keycode = 8'h00; note_spawn = 4'h0;
      repeat (3) @(negedge Clk);
      reset = 1'b0;
      sb.delete();
      tb_frame  = 16'h0000;
      exp_score = 16'h0000;
      exp_combo = 8'h00;
      for (int l = 0; l < 4; l++) m_cnt[l] = 0;
   endtask

   task automatic frame_tick();
      @(negedge Clk) vsync = 1'b1;
      @(negedge Clk) vsync = 1'b0;
      tb_frame = tb_frame + 16'd1;
      model_scan();
      repeat (7) @(negedge Clk);
   endtask

   task automatic tick_to(input logic [15:0] target);
      while (tb_frame != target) frame_tick();
   endtask

   task automatic spawn(input logic [3:0] mask);
      for (int l = 0; l < 4; l++) begin
         if (mask[l] && m_cnt[l] < DEPTH) begin
            m_q[l][m_cnt[l]] = tb_frame + 16'(TRAVEL);
            m_cnt[l]++;
         end
      end
      @(negedge Clk) note_spawn = mask;
      @(negedge Clk) note_spawn = 4'h0;
   endtask

   task automatic press_key(input logic [7:0] kc);
      model_key(kc);
      @(negedge Clk) begin keycode = kc; press = 1'b1; end
      @(negedge Clk) press = 1'b0;
      repeat (6) @(negedge Clk);
   endtask

   task automatic check_drained(input string name);
      n_checks++;
      if (sb.size() != 0)
         $display("FAIL %s_drained: got %0d judgements still outstanding, required 0", name, sb.size());
      else
         n_pass++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      @(negedge Clk);
      n_checks++;
      if (judge_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", judge_valid);
      else n_pass++;
      n_checks++;
      if ({judge_code, judge_lane} !== 4'h0) $display("FAIL reset_code_lane: got %h, required 0", {judge_code, judge_lane});
      else n_pass++;
      n_checks++;
      if (score !== 16'h0000) $display("FAIL reset_score: got %h, required 0000", score);
      else n_pass++;
      n_checks++;
      if (combo !== 8'h00) $display("FAIL reset_combo: got %h, required 00", combo);
      else n_pass++;
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b, required 0", overflow);
      else n_pass++;
   endtask

   task automatic test_perfect();
      do_reset();
      spawn(4'b0001);
      tick_to(16'd121);
      press_key(8'h6B);
      press_key(8'h6B);   // lane now empty: nothing expected
      check_drained("perfect");
   endtask

   task automatic test_good();
      do_reset();
      spawn(4'b1000);
      tick_to(16'd127);
      press_key(8'h74);
      check_drained("good");
   endtask

   task automatic test_early_then_miss();
      do_reset();
      spawn(4'b0011);
      tick_to(16'd100);
      press_key(8'h72);   // 20 frames early: ignored, note kept
      tick_to(16'd120);
      press_key(8'h6B);
      tick_to(16'd130);
      check_drained("early_miss");
      n_checks++;
      if (combo !== 8'd0 || score !== 16'd3)
         $display("FAIL early_miss_totals: got score=%0d combo=%0d, required score=3 combo=0", score, combo);
      else n_pass++;
   endtask

   task automatic test_overflow();
      do_reset();
      repeat (4) spawn(4'b0100);
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL overflow_early: got %b, required 0", overflow);
      else n_pass++;
      spawn(4'b0100);
      @(negedge Clk);
      n_checks++;
      if (overflow !== 1'b1) $display("FAIL overflow_set: got %b, required 1", overflow);
      else n_pass++;
      press_key(8'h1C);   // unmapped key
      tick_to(16'd120);
      repeat (5) press_key(8'h75);
      check_drained("overflow");
      n_checks++;
      if (overflow !== 1'b1) $display("FAIL overflow_sticky: got %b, required 1", overflow);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      spawn(4'b1111);
      tick_to(16'd119);
      press_key(8'h6B);
      press_key(8'h72);
      press_key(8'h75);
      press_key(8'h74);
      check_drained("back_to_back");
   endtask

   task automatic test_wrap();
      do_reset();
      @(negedge Clk) force dut.r_frame_cnt = 16'hFFD0;
      @(negedge Clk) release dut.r_frame_cnt;
      tb_frame = 16'hFFD0;
      spawn(4'b0001);     // due at 16'h0048
      tick_to(16'h0048);
      press_key(8'h6B);
      check_drained("wrap");
   endtask

   task automatic test_simultaneous();
      do_reset();
      spawn(4'b0010);     // lane1 due 120
      tick_to(16'd3);
      spawn(4'b0001);     // lane0 due 123
      tick_to(16'd128);
      @(negedge Clk) vsync = 1'b1;
      @(negedge Clk) begin vsync = 1'b0; keycode = 8'h6B; press = 1'b1; end
      tb_frame = tb_frame + 16'd1;   // 129: key judged first, then the sweep
      model_key(8'h6B);
      model_scan();
      @(negedge Clk) press = 1'b0;
      repeat (10) @(negedge Clk);
      check_drained("simultaneous");
   endtask

   task automatic test_reset_mid_scan();
      do_reset();
      spawn(4'b0011);
      tick_to(16'd120);
      press_key(8'h6B);
      tick_to(16'd128);
      check_drained("pre_reset");
      @(negedge Clk) vsync = 1'b1;
      @(negedge Clk) vsync = 1'b0;   // lane1 becomes overdue at frame 129
      repeat (3) @(negedge Clk);     // FSM now in SCAN1
      reset = 1'b1;
      @(negedge Clk);
      n_checks++;
      if (judge_valid !== 1'b0) $display("FAIL scan_reset_valid: got %b, required 0", judge_valid);
      else n_pass++;
      n_checks++;
      if ({judge_code, judge_lane, score, combo, overflow} !== 29'h0)
         $display("FAIL scan_reset_outputs: got code=%0d lane=%0d score=%0d combo=%0d ovf=%b, required all 0",
                  judge_code, judge_lane, score, combo, overflow);
      else n_pass++;
      repeat (2) @(negedge Clk);
      reset = 1'b0;
      tb_frame  = 16'h0000;
      exp_score = 16'h0000;
      exp_combo = 8'h00;
      for (int l = 0; l < 4; l++) m_cnt[l] = 0;
      repeat (3) frame_tick();      // FIFOs were flushed: no stale miss
      check_drained("scan_reset");
   endtask

   initial begin
      reset = 1'b1; vsync = 1'b0; press = 1'b0; keycode = 8'h00; note_spawn = 4'h0;
      test_reset();
      test_perfect();
      test_good();
      test_early_then_miss();
      test_overflow();
      test_back_to_back();
      test_wrap();
      test_simultaneous();
      test_reset_mid_scan();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
